// File: rtl/rs_chk_pkg.sv
// Shared types and constants for the RS flip-flop checker.
// The state enum, the {S,R} input encodings and the default counter width.
package rs_chk_pkg;
    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        KNOWN   = 2'd1,
        FORBID  = 2'd2
    } chk_state_t;

    // {S,R} encodings as sampled from the flip-flop inputs
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_BAD  = 2'b11;

    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/rs_ff_checker_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            count <= '0;
        else if (en && inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/rs_ff_checker.sv
// Self-checking monitor for a gated NAND RS flip-flop: models expected Q from
// the sampled S/R, compares one clock later, and counts errors and R=S=1 events.
module rs_ff_checker
    import rs_chk_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit CHK_QBAR = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             Qbar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] forbid_count
);
    chk_state_t state, state_nxt;
    logic       exp_q_nxt;
    logic       cmp_pending;
    logic       q_err, qbar_err, err_hit;
    logic [1:0] sr;

    assign sr        = {S, R};
    assign exp_valid = (state == KNOWN);

    // Compare uses the model registered at the previous enabled edge.
    // Q=Qbar is only an error when coming from KNOWN; both high is legal in FORBID.
    assign q_err    = cmp_pending && (Q != exp_q);
    assign qbar_err = CHK_QBAR && (state == KNOWN) && (Qbar == Q);
    assign err_hit  = q_err || qbar_err;

    always_comb begin
        state_nxt = state;
        exp_q_nxt = exp_q;
        case (sr)
            SR_SET: begin
                state_nxt = KNOWN;
                exp_q_nxt = 1'b1;
            end
            SR_RST: begin
                state_nxt = KNOWN;
                exp_q_nxt = 1'b0;
            end
            SR_BAD:  state_nxt = FORBID;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= UNKNOWN;
            exp_q       <= 1'b0;
            cmp_pending <= 1'b0;
            mismatch    <= 1'b0;
            err_sticky  <= 1'b0;
        end else if (en) begin
            state       <= state_nxt;
            exp_q       <= exp_q_nxt;
            cmp_pending <= (state_nxt == KNOWN);
            mismatch    <= err_hit;
            if (err_hit)
                err_sticky <= 1'b1;
        end else begin
            // a pulse cannot be frozen high; everything else holds
            mismatch <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clear (clear),
        .en    (en),
        .inc   (err_hit),
        .count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_forbid_cnt (
        .clk   (clk),
        .clear (clear),
        .en    (en),
        .inc   (sr == SR_BAD),
        .count (forbid_count)
    );
endmodule

// File: tb/tb_rs_ff_checker.sv
// Scoreboard bench for rs_ff_checker: two instances (8-bit/Qbar-checked and
// 2-bit/no-Qbar) share stimulus; a behavioural model predicts every clock.
module tb_rs_ff_checker;
    logic clk = 1'b0;
    logic clear = 1'b1, en = 1'b0, R = 1'b0, S = 1'b0, Q = 1'b0, Qbar = 1'b1;
    logic       exp_q0, exp_valid0, mismatch0, err_sticky0;
    logic [7:0] err_count0, forbid_count0;
    logic       exp_q1, exp_valid1, mismatch1, err_sticky1;
    logic [1:0] err_count1, forbid_count1;

    always #5 clk = ~clk;

    rs_ff_checker #(.CNT_W(8), .CHK_QBAR(1'b1)) dut (
        .clk(clk), .clear(clear), .en(en), .R(R), .S(S), .Q(Q), .Qbar(Qbar),
        .exp_q(exp_q0), .exp_valid(exp_valid0), .mismatch(mismatch0),
        .err_sticky(err_sticky0), .err_count(err_count0), .forbid_count(forbid_count0)
    );

    rs_ff_checker #(.CNT_W(2), .CHK_QBAR(1'b0)) dut2 (
        .clk(clk), .clear(clear), .en(en), .R(R), .S(S), .Q(Q), .Qbar(Qbar),
        .exp_q(exp_q1), .exp_valid(exp_valid1), .mismatch(mismatch1),
        .err_sticky(err_sticky1), .err_count(err_count1), .forbid_count(forbid_count1)
    );

    typedef struct {
        bit eq, ev, mm0, mm1, st0, st1;
        int ec0, ec1, fc0, fc1;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Behavioural model: mode 0 = nothing known yet, 1 = Q defined, 2 = after R=S=1
    int mode = 0;
    bit mq = 1'b0;
    int nerr0 = 0, nerr1 = 0, nforb = 0;
    bit mm0 = 1'b0, mm1 = 1'b0;

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.eq  = mq;
        e.ev  = (mode == 1);
        e.mm0 = mm0;
        e.mm1 = mm1;
        e.st0 = (nerr0 > 0);
        e.st1 = (nerr1 > 0);
        e.ec0 = sat(nerr0, 255);
        e.ec1 = sat(nerr1, 3);
        e.fc0 = sat(nforb, 255);
        e.fc1 = sat(nforb, 3);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus. qerr flips Q away from the correct value,
    // qbeq drives Qbar equal to Q instead of its complement.
    task automatic cycle(input bit cl, input bit e, input bit s, input bit r,
                         input bit qerr, input bit qbeq);
        bit was_clear;
        bit q;
        @(negedge clk);
        was_clear = clear;
        q = mq ^ qerr;
        clear = cl; en = e; S = s; R = r; Q = q; Qbar = qbeq ? q : ~q;
        if (cl) begin
            mode = 0; mq = 1'b0; nerr0 = 0; nerr1 = 0; nforb = 0;
            mm0 = 1'b0; mm1 = 1'b0;
            sb.push_back(snap());
            if (!was_clear) begin
                #1;
                chk("async_clr_err_count", int'(err_count0), 0);
                chk("async_clr_forbid", int'(forbid_count0), 0);
                chk("async_clr_sticky", int'(err_sticky1), 0);
                chk("async_clr_valid", int'(exp_valid0), 0);
            end
        end else begin
            if (e) begin
                mm0 = (mode == 1) && ((q != mq) || (Qbar == q));
                mm1 = (mode == 1) && (q != mq);
                nerr0 += int'(mm0);
                nerr1 += int'(mm1);
                if (s && !r) begin mq = 1'b1; mode = 1; end
                else if (r && !s) begin mq = 1'b0; mode = 1; end
                else if (s && r) begin mode = 2; nforb++; end
            end else begin
                mm0 = 1'b0;
                mm1 = 1'b0;
            end
            sb.push_back(snap());
        end
    endtask

    // Monitor: every clock the checker presents a result; compare it away from the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("exp_q", int'(exp_q0), int'(x.eq));
                chk("exp_valid", int'(exp_valid0), int'(x.ev));
                chk("mismatch", int'(mismatch0), int'(x.mm0));
                chk("err_sticky", int'(err_sticky0), int'(x.st0));
                chk("err_count", int'(err_count0), x.ec0);
                chk("forbid_count", int'(forbid_count0), x.fc0);
                chk("w2_exp_q", int'(exp_q1), int'(x.eq));
                chk("w2_mismatch", int'(mismatch1), int'(x.mm1));
                chk("w2_err_sticky", int'(err_sticky1), int'(x.st1));
                chk("w2_err_count", int'(err_count1), x.ec1);
                chk("w2_forbid_count", int'(forbid_count1), x.fc1);
            end
        end
    end

    initial begin
        // reset, then only holds: nothing should fire
        repeat (2) cycle(1, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        // set, hold, reset with a well-behaved flip-flop
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        // set, then one wrong Q, then corrected
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        // forbidden inputs, lingering holds, then recovery
        repeat (3) cycle(0, 1, 1, 1, 0, 1);
        repeat (2) cycle(0, 1, 0, 0, $urandom_range(0, 1), 1);
        cycle(0, 1, 1, 0, 0, 1);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // disabled while Q toggles and S/R move
        for (int i = 0; i < 5; i++) cycle(0, 0, i[0], ~i[0], i[0], 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // Q=Qbar=1 while KNOWN with exp_q=1
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0);
        // six wrong Q cycles to saturate the narrow counter
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 0, 1, 0);
            cycle(0, 1, 0, 0, 0, 0);
        end
        // clear mid-run, then holds only
        repeat (2) cycle(1, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 14) == 0));
        end
        repeat (3) @(posedge clk);
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
